// File: rtl/izn_sched_pkg.sv
// Shared constants for the Izhikevich sweep scheduler.
// Holds FSM state encodings, default sizing and current-word width.
package izn_sched_pkg;

    localparam int N_NEURON_DEF = 128;
    localparam int IDX_W_DEF    = 7;
    localparam int CUR_W        = 32;
    localparam int OVR_W        = 16;

    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] state_t;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
    localparam logic [ST_W-1:0] ST_READ  = 3'd2;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

    function automatic logic st_busy(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/izn_sweep_sched_if.sv
// Valid/ready stream carrying input-current words into the scheduler.
// master = upstream current source, slave = scheduler.
interface izn_sweep_sched_if
    import izn_sched_pkg::*;
    ;
    logic             i_valid;
    logic [CUR_W-1:0] i_data;
    logic             i_ready;

    modport master (output i_valid, output i_data, input i_ready);
    modport slave  (input i_valid, input i_data, output i_ready);
endinterface

// File: rtl/izn_sat_counter.sv
// Saturating up-counter used to tally rejected sweep requests.
// Holds at all-ones once reached.
module izn_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/izn_sweep_sched.sv
// Sweep scheduler: walks all neurons once per tick, one current word each.
// Define IZN_OVERRUN_CNT_EN to count ticks that arrive while a sweep runs.
module izn_sweep_sched
    import izn_sched_pkg::*;
#(
    parameter int N_NEURON = N_NEURON_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    izn_sweep_sched_if.slave    cur,
    output logic [IDX_W-1:0]    idx,
    output logic [CUR_W-1:0]    i_hold,
    output logic                mem_we,
    output logic                first_pass,
    input  logic                fired,
    output logic                busy,
    output logic                done,
    output logic [N_NEURON-1:0] population,
    output logic [OVR_W-1:0]    overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURON - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CUR_W-1:0]    hold_q, hold_d;
    logic [N_NEURON-1:0] raster_q, raster_d;
    logic [N_NEURON-1:0] pop_q, pop_d;
    logic                fp_q, fp_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        raster_d = raster_q;
        pop_d    = pop_q;
        fp_d     = fp_q;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            (state_q == ST_FETCH): begin
                if (cur.i_valid) begin
                    hold_d  = cur.i_data;
                    state_d = ST_READ;
                end
            end
            (state_q == ST_READ): begin
                state_d = ST_WRITE;
            end
            (state_q == ST_WRITE): begin
                raster_d[idx_q] = fired;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            (state_q == ST_DONE): begin
                // Raster is published only here so partial sweeps stay hidden.
                pop_d   = raster_q;
                fp_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            raster_q <= '0;
            pop_q    <= '0;
            fp_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            raster_q <= raster_d;
            pop_q    <= pop_d;
            fp_q     <= fp_d;
        end
    end

    assign idx         = idx_q;
    assign i_hold      = hold_q;
    assign population  = pop_q;
    assign first_pass  = fp_q;
    assign cur.i_ready = (state_q == ST_FETCH);
    assign mem_we      = (state_q == ST_WRITE);
    assign done        = (state_q == ST_DONE);
    assign busy        = st_busy(state_q);

`ifdef IZN_OVERRUN_CNT_EN
    izn_sat_counter #(
        .W (OVR_W)
    ) u_ovr (
        .clk   (clk),
        .rst   (reset),
        .inc_i (tick && busy),
        .cnt_o (overrun)
    );
`else
    assign overrun = '0;
`endif

endmodule

// File: tb/tb_izn_sweep_sched.sv
// Directed bench for izn_sweep_sched: full sweeps, backpressure,
// overrun ticks, mid-sweep reset and back-to-back sweeps.
module tb_izn_sweep_sched;

    localparam int N  = 128;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          fired;
    logic [IW-1:0] idx;
    logic [31:0]   i_hold;
    logic          mem_we;
    logic          first_pass;
    logic          busy;
    logic          done;
    logic [N-1:0]  population;
    logic [15:0]   overrun;

    int n_cmp = 0;
    int n_err = 0;

    izn_sweep_sched_if cur ();

    izn_sweep_sched #(
        .N_NEURON (N),
        .IDX_W    (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .cur        (cur.slave),
        .idx        (idx),
        .i_hold     (i_hold),
        .mem_we     (mem_we),
        .first_pass (first_pass),
        .fired      (fired),
        .busy       (busy),
        .done       (done),
        .population (population),
        .overrun    (overrun)
    );

    // Datapath stand-in: only neuron 5 crosses threshold.
    assign fired = mem_we && (idx == 7'd5);

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string tag,
                         input logic exp_fp,
                         input int stall_n,
                         input int t_a,
                         input int t_b,
                         input int rst_at,
                         input logic [N-1:0] pop_old,
                         output int done_cyc,
                         output int we_cnt,
                         output bit aborted);
        int cyc;
        int stalls;
        bit pend;
        bit seen;
        logic [31:0] hexp;
        cyc = 0;
        stalls = 0;
        pend = 0;
        seen = 0;
        hexp = '0;
        done_cyc = -1;
        we_cnt = 0;
        aborted = 0;
        tick = 1'b1;
        cur.i_valid = 1'b1;
        cur.i_data = 32'h4000_0000;
        step();
        cyc = 1;
        while (!seen && !aborted && cyc < 600) begin
            if (cyc == rst_at) begin
                reset = 1'b1;
                tick = 1'b0;
                #1;
                chk({tag, " rst busy"}, busy, 1'b0);
                chk({tag, " rst mem_we"}, mem_we, 1'b0);
                chk({tag, " rst idx"}, idx, 0);
                step();
                step();
                reset = 1'b0;
                aborted = 1;
            end else begin
                tick = (cyc == t_a) || (cyc == t_b);
                if (cur.i_ready && idx == 7'd10 && stalls < stall_n) begin
                    cur.i_valid = 1'b0;
                    stalls++;
                end else begin
                    cur.i_valid = 1'b1;
                end
                cur.i_data = 32'h4000_0000 + 32'(cyc);
                if (pend) begin
                    chk({tag, " i_hold idx10"}, i_hold, hexp);
                    pend = 0;
                end
                if (cur.i_ready && cur.i_valid && idx == 7'd10) begin
                    hexp = cur.i_data;
                    pend = 1;
                end
                if (mem_we) begin
                    chk({tag, " we idx"}, idx, we_cnt[IW-1:0]);
                    we_cnt++;
                end
                chk({tag, " first_pass"}, first_pass, exp_fp);
                chk({tag, " pop stable"}, population, pop_old);
                chk({tag, " busy"}, busy, 1'b1);
                if (done) begin
                    seen = 1;
                    done_cyc = cyc;
                end
                step();
                cyc++;
            end
        end
        tick = 1'b0;
        if (!aborted) begin
            chk({tag, " done seen"}, seen, 1'b1);
        end
    endtask

    initial begin
        int dc;
        int wc;
        bit ab;
        logic [N-1:0] p5;
        logic [15:0] ovr_exp;
        p5 = '0;
        p5[5] = 1'b1;
`ifdef IZN_OVERRUN_CNT_EN
        ovr_exp = 16'd2;
`else
        ovr_exp = 16'd0;
`endif
        cur.i_valid = 1'b0;
        cur.i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset idx", idx, 0);
        chk("reset i_hold", i_hold, 0);
        chk("reset population", population, 0);
        chk("reset overrun", overrun, 0);
        chk("reset first_pass", first_pass, 1'b1);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset i_ready", cur.i_ready, 1'b0);
        chk("reset done", done, 1'b0);
        reset = 1'b0;
        step();

        sweep("s1", 1'b1, 0, -1, -1, -1, '0, dc, wc, ab);
        chk("s1 done cycle", dc, 385);
        chk("s1 we count", wc, 128);
        chk("s1 idle busy", busy, 1'b0);
        chk("s1 first_pass after", first_pass, 1'b0);
        chk("s1 population", population, p5);

        sweep("s2", 1'b0, 0, -1, -1, -1, p5, dc, wc, ab);
        chk("s2 done abs cycle", 386 + dc, 771);
        chk("s2 we count", wc, 128);
        chk("s2 population", population, p5);

        step();
        step();
        sweep("s3", 1'b0, 4, 50, 200, -1, p5, dc, wc, ab);
        chk("s3 done cycle", dc, 389);
        chk("s3 we count", wc, 128);
        chk("s3 overrun", overrun, ovr_exp);
        chk("s3 population", population, p5);

        step();
        sweep("s4", 1'b0, 0, -1, -1, 100, p5, dc, wc, ab);
        chk("s4 aborted", ab, 1'b1);
        chk("s4 busy", busy, 1'b0);
        chk("s4 idx", idx, 0);
        chk("s4 population", population, 0);
        chk("s4 overrun", overrun, 0);
        chk("s4 first_pass", first_pass, 1'b1);

        step();
        sweep("s5", 1'b1, 0, -1, -1, -1, '0, dc, wc, ab);
        chk("s5 done cycle", dc, 385);
        chk("s5 we count", wc, 128);
        chk("s5 population", population, p5);
        chk("s5 first_pass after", first_pass, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/izn_sweep_sched.md
IZN_SWEEP_SCHED -- requirements
Module: izn_sweep_sched

Interface
REQ-001 SHALL have parameter N_NEURON, default 128: number of time-multiplexed neurons per sweep.
REQ-002 SHALL have parameter IDX_W, default 7: neuron index width, with 2**IDX_W >= N_NEURON.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  sweep start request, one integration step.
REQ-006 SHALL have port i_valid  input  1  upstream current word valid.
REQ-007 SHALL have port i_data  input  32  signed input current, scale 1024.
REQ-008 SHALL have port i_ready  output  1  scheduler accepts current word.
REQ-009 SHALL have port idx  output  IDX_W  neuron address driven to state RAMs.
REQ-010 SHALL have port i_hold  output  32  latched current presented to datapath.
REQ-011 SHALL have port mem_we  output  1  state-RAM write enable.
REQ-012 SHALL have port first_pass  output  1  datapath selects init values for u/v.
REQ-013 SHALL have port fired  input  1  datapath threshold-crossing flag for current idx.
REQ-014 SHALL have port busy  output  1  sweep in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-016 SHALL have port population  output  N_NEURON  spike raster of the last completed sweep.
REQ-017 SHALL have port overrun  output  16  count of rejected ticks.

Function
REQ-018 SHALL implement states IDLE, FETCH, READ, WRITE, DONE.
REQ-019 IDLE: tick=1 SHALL load idx=0 and enter FETCH next cycle; tick ignored in all other states.
REQ-020 FETCH: i_ready=1; on i_valid&i_ready SHALL latch i_data into i_hold and enter READ; otherwise stay in FETCH.
REQ-021 READ: SHALL hold idx and i_hold for one cycle (RAM read and datapath settle), then enter WRITE.
REQ-022 WRITE: mem_we=1 for exactly this cycle; SHALL capture fired into raster bit idx.
REQ-023 From WRITE: if idx==N_NEURON-1 enter DONE, else idx+1 and enter FETCH.
REQ-024 DONE: done=1 for one cycle; population <= raster; first_pass <= 0; return to IDLE.
REQ-025 busy SHALL be 1 in FETCH, READ, WRITE, DONE; 0 in IDLE.
REQ-026 mem_we, i_ready, done SHALL be 0 outside their own state.
REQ-027 With i_valid held high, tick at cycle 0 SHALL give FETCH for neuron j at cycle 1+3j, final WRITE at 384, done at 385, IDLE at 386 (N_NEURON=128).
REQ-028 Backpressure: each i_valid-low cycle in FETCH SHALL delay all subsequent events by one cycle; idx, raster unchanged.
REQ-029 first_pass SHALL remain 1 throughout the first complete sweep after reset.
REQ-030 population SHALL change only in DONE; partial sweeps never visible.

Reset
REQ-031 Reset SHALL force IDLE, idx=0, i_hold=0, raster=0, population=0, overrun=0, first_pass=1; mem_we, i_ready, done, busy=0.
REQ-032 Reset mid-sweep SHALL abort without completing the write; next sweep SHALL run with first_pass=1.

Configuration
REQ-033 Macro IZN_OVERRUN_CNT_EN defined: tick=1 in any non-IDLE state SHALL increment overrun, saturating at 16'hFFFF.
REQ-034 Macro undefined: overrun SHALL be constant 0 and no counter logic synthesized; tick behaviour otherwise identical.

Structure
REQ-035 Package izn_sched_pkg SHALL hold the state enumeration, default N_NEURON/IDX_W, and current width constant (32).
REQ-036 Saturating counter SHALL be sub-module izn_sat_counter, instantiated only under IZN_OVERRUN_CNT_EN.

Verification
REQ-037 Reset, tick at cycle 0, i_valid=1 constant -> done at cycle 385, 128 mem_we pulses at idx 0..127, first_pass 1 then 0 after done.
REQ-038 fired=1 only when idx==5 during WRITE -> population == 1<<5 after done; all zero before.
REQ-039 i_valid low 4 cycles at idx 10 -> done at 389; i_hold for idx 10 equals word accepted on first valid cycle.
REQ-040 Ticks at cycles 0, 50, 200 with IZN_OVERRUN_CNT_EN -> one sweep, overrun=2; undefined -> overrun=0.
REQ-041 Reset asserted at cycle 100, released at 102 -> IDLE, idx=0, population=0, next sweep first_pass=1.
REQ-042 Second sweep back-to-back (tick at 386) -> first_pass=0 throughout, done at 771.
